// File: rtl/intr_arbiter_pkg.sv
// Shared types and limits for the interrupt arbiter.
package intr_arbiter_pkg;

    // The CPU cause field is 4 bits wide, which caps the number of sources.
    localparam int INT_SRC_MAX = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2,
        HOLD = 2'd3
    } arb_state_t;

endpackage

// File: rtl/intr_prio_enc.sv
// Fixed-priority encoder: one-hot of the lowest set bit plus an any-valid flag.
module intr_prio_enc #(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0] req,
    output logic [N_SRC-1:0] onehot,
    output logic             any
);

    // Scan from bit 0 upward; the first set bit wins and blocks the rest.
    always_comb begin
        onehot = '0;
        any    = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (req[i] && !any) begin
                onehot[i] = 1'b1;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intr_arbiter.sv
// Interrupt arbiter: latches source edges, masks with the CPU enable register,
// grants one source by fixed priority and runs the Ireq/Iack handshake.
module intr_arbiter
    import intr_arbiter_pkg::*;
#(
    parameter int N_SRC = 4,   // 1..INT_SRC_MAX
    parameter bit EDGE  = 1'b1 // 1: rising-edge capture, 0: level capture
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_i,
    input  logic [31:0]      int_en_i,
    input  logic             Iack,
    output logic             Ireq,
    output logic [N_SRC-1:0] gntInt,
    output logic [N_SRC-1:0] irq_ack_o,
    output logic [N_SRC-1:0] pending_o
);

    arb_state_t       state, state_nxt;
    logic [N_SRC-1:0] irq_d;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] set_req;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] masked;
    logic [N_SRC-1:0] pick;
    logic             pick_any;

    logic             ireq_q, ireq_nxt;
    logic [N_SRC-1:0] gnt_q, gnt_nxt;
    logic [N_SRC-1:0] ack_q, ack_nxt;

    // Only the low N_SRC enable bits belong to this block.
    logic unused_en;
    assign unused_en = ^int_en_i[31:N_SRC];

    assign rise    = irq_i & ~irq_d;
    assign set_req = EDGE ? rise : irq_i;
    assign masked  = pending & int_en_i[N_SRC-1:0];

    intr_prio_enc #(.N_SRC(N_SRC)) u_prio (
        .req    (masked),
        .onehot (pick),
        .any    (pick_any)
    );

    // Edge detector and pending register; a new set beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_d   <= '0;
            pending <= '0;
        end else begin
            irq_d   <= irq_i;
            pending <= set_req | (pending & ~clr);
        end
    end

    // State and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ireq_q <= 1'b0;
            gnt_q  <= '0;
            ack_q  <= '0;
        end else begin
            state  <= state_nxt;
            ireq_q <= ireq_nxt;
            gnt_q  <= gnt_nxt;
            ack_q  <= ack_nxt;
        end
    end

    // Next-state logic. The clear is issued on the REQ->ACK transition so the
    // pending bit is already gone while the ack pulse is visible; an edge that
    // arrives during ACK therefore re-latches cleanly.
    always_comb begin
        state_nxt = state;
        ireq_nxt  = ireq_q;
        gnt_nxt   = gnt_q;
        ack_nxt   = '0;
        clr       = '0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt = REQ;
                    ireq_nxt  = 1'b1;
                    gnt_nxt   = pick;
                end
            end
            REQ: begin
                // Grant is frozen here: masking or a higher-priority arrival
                // must not disturb what the CPU is sampling.
                if (Iack) begin
                    state_nxt = ACK;
                    ireq_nxt  = 1'b0;
                    gnt_nxt   = '0;
                    ack_nxt   = gnt_q;
                    clr       = gnt_q;
                end
            end
            ACK: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                if (!Iack) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                ireq_nxt  = 1'b0;
                gnt_nxt   = '0;
            end
        endcase
    end

    assign Ireq      = ireq_q;
    assign gntInt    = gnt_q;
    assign irq_ack_o = ack_q;
    assign pending_o = pending;

endmodule

// File: tb/tb_intr_arbiter.sv
// Self-checking bench for intr_arbiter: per-scenario tasks with inline checks,
// plus a monitor that pops expected grants/acks from scoreboard queues.
module tb_intr_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] irq_i;
    logic [31:0]  int_en_i;
    logic         Iack;
    logic         Ireq;
    logic [N-1:0] gntInt;
    logic [N-1:0] irq_ack_o;
    logic [N-1:0] pending_o;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] exp_gnt_q[$];
    logic [N-1:0] exp_ack_q[$];

    intr_arbiter #(.N_SRC(N), .EDGE(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_i     (irq_i),
        .int_en_i  (int_en_i),
        .Iack      (Iack),
        .Ireq      (Ireq),
        .gntInt    (gntInt),
        .irq_ack_o (irq_ack_o),
        .pending_o (pending_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ireq(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= max; i++) begin
            if (Ireq === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (i < max) tick();
        end
    endtask

    task automatic do_handshake();
        Iack = 1'b1;
        tick();
        tick();
        Iack = 1'b0;
        tick();
        tick();
    endtask

    // Scoreboard monitor: new grants and ack pulses are compared on the falling edge.
    logic         ireq_prev = 1'b0;
    logic [N-1:0] gnt_prev  = '0;
    always @(negedge clk) begin
        logic [N-1:0] e;
        if (Ireq === 1'b1 && ireq_prev !== 1'b1) begin
            checks++;
            if (exp_gnt_q.size() == 0) begin
                errors++;
                $display("FAIL sb_grant unexpected gntInt=%b", gntInt);
            end else begin
                e = exp_gnt_q.pop_front();
                if (gntInt !== e) begin
                    errors++;
                    $display("FAIL sb_grant got=%b exp=%b", gntInt, e);
                end
            end
        end
        if (Ireq === 1'b1 && ireq_prev === 1'b1) begin
            checks++;
            if (gntInt !== gnt_prev) begin
                errors++;
                $display("FAIL gnt_stable got=%b exp=%b", gntInt, gnt_prev);
            end
        end
        if ((|irq_ack_o) === 1'b1) begin
            checks++;
            if (exp_ack_q.size() == 0) begin
                errors++;
                $display("FAIL sb_ack unexpected irq_ack_o=%b", irq_ack_o);
            end else begin
                e = exp_ack_q.pop_front();
                if (irq_ack_o !== e) begin
                    errors++;
                    $display("FAIL sb_ack got=%b exp=%b", irq_ack_o, e);
                end
            end
        end
        ireq_prev = Ireq;
        gnt_prev  = gntInt;
    end

    task automatic test_reset();
        reset = 1'b1; irq_i = '0; int_en_i = 32'h0; Iack = 1'b0;
        repeat (3) tick();
        checks++;
        if (Ireq !== 1'b0 || gntInt !== '0 || irq_ack_o !== '0 || pending_o !== '0) begin
            errors++;
            $display("FAIL reset got Ireq=%b gnt=%b ack=%b pend=%b exp all 0",
                     Ireq, gntInt, irq_ack_o, pending_o);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int_en_i = 32'hF;
        exp_gnt_q.push_back(4'b0100);
        exp_ack_q.push_back(4'b0100);
        irq_i = 4'b0100;
        tick();
        checks++;
        if (pending_o !== 4'b0100 || Ireq !== 1'b0) begin
            errors++;
            $display("FAIL single_pend got pend=%b Ireq=%b exp 0100/0", pending_o, Ireq);
        end
        tick();
        checks++;
        if (Ireq !== 1'b1 || gntInt !== 4'b0100) begin
            errors++;
            $display("FAIL single_req got Ireq=%b gnt=%b exp 1/0100", Ireq, gntInt);
        end
        tick();
        tick();
        Iack = 1'b1;
        tick();
        checks++;
        if (irq_ack_o !== 4'b0100 || pending_o !== '0 || Ireq !== 1'b0 || gntInt !== '0) begin
            errors++;
            $display("FAIL single_ack got ack=%b pend=%b Ireq=%b gnt=%b exp 0100/0000/0/0000",
                     irq_ack_o, pending_o, Ireq, gntInt);
        end
        tick();
        checks++;
        if (irq_ack_o !== '0) begin
            errors++;
            $display("FAIL single_ack_pulse got=%b exp=0000", irq_ack_o);
        end
        Iack = 1'b0;
        irq_i = '0;
        tick();
        tick();
    endtask

    task automatic test_priority();
        bit ok;
        exp_gnt_q.push_back(4'b0010);
        exp_ack_q.push_back(4'b0010);
        exp_gnt_q.push_back(4'b1000);
        exp_ack_q.push_back(4'b1000);
        irq_i = 4'b1010;
        wait_ireq(4, ok);
        checks++;
        if (!ok || gntInt !== 4'b0010) begin
            errors++;
            $display("FAIL prio_first got ok=%0d gnt=%b exp 1/0010", ok, gntInt);
        end
        Iack = 1'b1;
        tick();
        tick();
        Iack = 1'b0;
        wait_ireq(2, ok);
        checks++;
        if (!ok || gntInt !== 4'b1000) begin
            errors++;
            $display("FAIL prio_second got ok=%0d gnt=%b exp 1/1000", ok, gntInt);
        end
        do_handshake();
        irq_i = '0;
        tick();
    endtask

    task automatic test_mask_hold();
        bit ok;
        exp_gnt_q.push_back(4'b0100);
        exp_ack_q.push_back(4'b0100);
        exp_gnt_q.push_back(4'b0001);
        exp_ack_q.push_back(4'b0001);
        irq_i = 4'b0100;
        wait_ireq(3, ok);
        checks++;
        if (!ok || gntInt !== 4'b0100) begin
            errors++;
            $display("FAIL mask_req got ok=%0d gnt=%b exp 1/0100", ok, gntInt);
        end
        irq_i = 4'b0101;
        int_en_i = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (Ireq !== 1'b1 || gntInt !== 4'b0100) begin
                errors++;
                $display("FAIL mask_frozen got Ireq=%b gnt=%b exp 1/0100", Ireq, gntInt);
            end
        end
        do_handshake();
        tick();
        tick();
        checks++;
        if (Ireq !== 1'b0 || pending_o !== 4'b0001) begin
            errors++;
            $display("FAIL mask_blocked got Ireq=%b pend=%b exp 0/0001", Ireq, pending_o);
        end
        int_en_i = 32'h1;
        wait_ireq(2, ok);
        checks++;
        if (!ok || gntInt !== 4'b0001) begin
            errors++;
            $display("FAIL mask_enable got ok=%0d gnt=%b exp 1/0001", ok, gntInt);
        end
        do_handshake();
        irq_i = '0;
        int_en_i = 32'hF;
        tick();
    endtask

    task automatic test_back_to_back();
        bit ok;
        exp_gnt_q.push_back(4'b0010);
        exp_ack_q.push_back(4'b0010);
        exp_gnt_q.push_back(4'b0010);
        exp_ack_q.push_back(4'b0010);
        irq_i = 4'b0010;
        tick();
        irq_i = '0;
        wait_ireq(3, ok);
        checks++;
        if (!ok || gntInt !== 4'b0010) begin
            errors++;
            $display("FAIL b2b_req got ok=%0d gnt=%b exp 1/0010", ok, gntInt);
        end
        Iack = 1'b1;
        tick();
        checks++;
        if (pending_o[1] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_clear got pend=%b exp bit1=0", pending_o);
        end
        irq_i = 4'b0010;
        tick();
        checks++;
        if (pending_o[1] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_set_wins got pend=%b exp bit1=1", pending_o);
        end
        Iack = 1'b0;
        irq_i = '0;
        wait_ireq(2, ok);
        checks++;
        if (!ok || gntInt !== 4'b0010) begin
            errors++;
            $display("FAIL b2b_rereq got ok=%0d gnt=%b exp 1/0010", ok, gntInt);
        end
        do_handshake();
        tick();
    endtask

    task automatic test_reset_hold();
        bit ok;
        exp_gnt_q.push_back(4'b0001);
        exp_ack_q.push_back(4'b0001);
        irq_i = 4'b0001;
        wait_ireq(3, ok);
        checks++;
        if (!ok || gntInt !== 4'b0001) begin
            errors++;
            $display("FAIL rsth_req got ok=%0d gnt=%b exp 1/0001", ok, gntInt);
        end
        irq_i = 4'b1011;
        tick();
        Iack = 1'b1;
        tick();
        tick();
        checks++;
        if (pending_o !== 4'b1010) begin
            errors++;
            $display("FAIL rsth_pend got=%b exp=1010", pending_o);
        end
        reset = 1'b1;
        irq_i = '0;
        tick();
        checks++;
        if (Ireq !== 1'b0 || gntInt !== '0 || irq_ack_o !== '0 || pending_o !== '0) begin
            errors++;
            $display("FAIL rsth_clear got Ireq=%b gnt=%b ack=%b pend=%b exp all 0",
                     Ireq, gntInt, irq_ack_o, pending_o);
        end
        reset = 1'b0;
        Iack = 1'b0;
        repeat (5) tick();
        checks++;
        if (Ireq !== 1'b0 || pending_o !== '0) begin
            errors++;
            $display("FAIL rsth_after got Ireq=%b pend=%b exp 0/0000", Ireq, pending_o);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_mask_hold();
        test_back_to_back();
        test_reset_hold();
        checks++;
        if (exp_gnt_q.size() != 0 || exp_ack_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got gnt_left=%0d ack_left=%0d exp 0/0",
                     exp_gnt_q.size(), exp_ack_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop so the run can never hang.
    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
